// File: rtl/lcd_char_driver.sv
// HD44780 16x2 character-LCD bus driver: power-up init command sequence, then a
// continuous 32-character refresh paced by rising edges of the 1 kHz divider strobe.
module lcd_char_driver #(
    parameter int POWERUP_TICKS = 20,
    parameter int CLEAR_TICKS   = 3
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       clk_1khz,
    input  logic       enable,
    output logic [4:0] char_addr,
    input  logic [7:0] char_data,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       frame_done
);

    localparam logic [2:0] ST_POWER_WAIT = 3'd0;
    localparam logic [2:0] ST_INIT       = 3'd1;
    localparam logic [2:0] ST_CLEAR_WAIT = 3'd2;
    localparam logic [2:0] ST_FRAME      = 3'd3;
    localparam logic [2:0] ST_IDLE       = 3'd4;

    localparam logic [1:0] PH_SETUP = 2'd0;
    localparam logic [1:0] PH_PULSE = 2'd1;
    localparam logic [1:0] PH_HOLD  = 2'd2;

    localparam int         CNT_W          = 16;
    localparam logic [5:0] LAST_INIT_IDX  = 6'd3;
    localparam logic [5:0] LINE2_CMD_IDX  = 6'd17;
    localparam logic [5:0] LAST_FRAME_IDX = 6'd33;

    localparam logic [7:0] CMD_LINE1 = 8'h80;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;

    localparam logic [CNT_W-1:0] POWERUP_CNT = CNT_W'(POWERUP_TICKS);
    localparam logic [CNT_W-1:0] CLEAR_CNT   = CNT_W'(CLEAR_TICKS);

    // Function set 8-bit/2-line, display on, entry mode increment, clear display.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    logic             clk_1khz_q;
    logic [2:0]       state_q,     state_d;
    logic [1:0]       phase_q,     phase_d;
    logic [5:0]       wr_idx_q,    wr_idx_d;
    logic [CNT_W-1:0] tick_cnt_q,  tick_cnt_d;
    logic [4:0]       char_addr_q, char_addr_d;
    logic             lcd_e_q,     lcd_e_d;
    logic             lcd_rs_q,    lcd_rs_d;
    logic [7:0]       lcd_data_q,  lcd_data_d;
    logic             init_done_q, init_done_d;
    logic             frame_done_q, frame_done_d;

    logic             tick;
    logic             at_boundary;
    logic [5:0]       next_idx;
    logic [CNT_W-1:0] cnt_inc;
    logic             hold_is_char;

    assign tick         = clk_1khz & ~clk_1khz_q;
    assign next_idx     = wr_idx_q + 6'd1;
    assign cnt_inc      = tick_cnt_q + CNT_W'(1);
    assign hold_is_char = (wr_idx_q != 6'd0) && (wr_idx_q != LINE2_CMD_IDX);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // case statements can leave it unassigned and infer a latch.
        state_d      = state_q;
        phase_d      = phase_q;
        wr_idx_d     = wr_idx_q;
        tick_cnt_d   = tick_cnt_q;
        char_addr_d  = char_addr_q;
        lcd_e_d      = lcd_e_q;
        lcd_rs_d     = lcd_rs_q;
        lcd_data_d   = lcd_data_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        at_boundary  = 1'b0;

        if (tick) begin
            case (state_q)
                ST_POWER_WAIT: begin
                    tick_cnt_d = cnt_inc;
                    if (cnt_inc == POWERUP_CNT) begin
                        state_d    = ST_INIT;
                        wr_idx_d   = 6'd0;
                        phase_d    = PH_SETUP;
                        lcd_e_d    = 1'b0;
                        lcd_rs_d   = 1'b0;
                        lcd_data_d = init_cmd(2'd0);
                    end
                end

                ST_INIT: begin
                    case (phase_q)
                        PH_SETUP: begin
                            lcd_e_d = 1'b1;
                            phase_d = PH_PULSE;
                        end
                        PH_PULSE: begin
                            lcd_e_d = 1'b0;
                            phase_d = PH_HOLD;
                            if (wr_idx_q == LAST_INIT_IDX) begin
                                state_d     = ST_CLEAR_WAIT;
                                tick_cnt_d  = '0;
                                char_addr_d = 5'd0;
                            end
                        end
                        default: begin
                            wr_idx_d   = next_idx;
                            phase_d    = PH_SETUP;
                            lcd_rs_d   = 1'b0;
                            lcd_data_d = init_cmd(next_idx[1:0]);
                        end
                    endcase
                end

                ST_CLEAR_WAIT: begin
                    if (tick_cnt_q == CLEAR_CNT) begin
                        init_done_d = 1'b1;
                        at_boundary = 1'b1;
                    end else begin
                        tick_cnt_d = cnt_inc;
                    end
                end

                ST_FRAME: begin
                    case (phase_q)
                        PH_SETUP: begin
                            lcd_e_d = 1'b1;
                            phase_d = PH_PULSE;
                        end
                        PH_PULSE: begin
                            lcd_e_d = 1'b0;
                            phase_d = PH_HOLD;
                            // 5-bit address wraps 31 -> 0 on the last character.
                            if (hold_is_char) begin
                                char_addr_d = char_addr_q + 5'd1;
                            end
                            if (wr_idx_q == LAST_FRAME_IDX) begin
                                frame_done_d = 1'b1;
                                state_d      = ST_IDLE;
                            end
                        end
                        default: begin
                            wr_idx_d = next_idx;
                            phase_d  = PH_SETUP;
                            if (next_idx == LINE2_CMD_IDX) begin
                                lcd_rs_d   = 1'b0;
                                lcd_data_d = CMD_LINE2;
                            end else begin
                                lcd_rs_d   = 1'b1;
                                lcd_data_d = char_data;
                            end
                        end
                    endcase
                end

                ST_IDLE: begin
                    at_boundary = 1'b1;
                end

                default: begin
                    state_d = ST_POWER_WAIT;
                end
            endcase
        end

        // enable is only looked at here, so mid-frame changes wait for the boundary.
        if (at_boundary) begin
            if (enable) begin
                state_d    = ST_FRAME;
                wr_idx_d   = 6'd0;
                phase_d    = PH_SETUP;
                lcd_e_d    = 1'b0;
                lcd_rs_d   = 1'b0;
                lcd_data_d = CMD_LINE1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            clk_1khz_q   <= 1'b0;
            state_q      <= ST_POWER_WAIT;
            phase_q      <= PH_SETUP;
            wr_idx_q     <= 6'd0;
            tick_cnt_q   <= '0;
            char_addr_q  <= 5'd0;
            lcd_e_q      <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= 8'h00;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values
            // computed above, independent of statement order.
            clk_1khz_q   <= clk_1khz;
            state_q      <= state_d;
            phase_q      <= phase_d;
            wr_idx_q     <= wr_idx_d;
            tick_cnt_q   <= tick_cnt_d;
            char_addr_q  <= char_addr_d;
            lcd_e_q      <= lcd_e_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_data_q   <= lcd_data_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign char_addr  = char_addr_q;
    assign lcd_e      = lcd_e_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = lcd_data_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_char_driver.sv
// Directed bench for lcd_char_driver: expected E-pulse words and their tick numbers
// are queued as stimulus is set up and popped whenever the DUT raises lcd_e.
module tb_lcd_char_driver;

    typedef struct {
        logic [8:0] word;
        int         tick;
    } exp_t;

    logic       clk_50mhz = 1'b0;
    logic       rst       = 1'b1;
    logic       clk_1khz  = 1'b0;
    logic       enable    = 1'b0;
    logic [4:0] char_addr;
    logic [7:0] char_data;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       init_done;
    logic       frame_done;

    exp_t       exp_q[$];
    int         vectors         = 0;
    int         miscompares     = 0;
    int         tick_num        = 0;
    int         last_pulse_tick = -100;
    int         fd_count        = 0;
    logic [8:0] last_pulse_word = '0;
    logic       prev_e          = 1'b0;
    logic       fd_pending      = 1'b0;

    // External character source: each cell holds 'A' + its index.
    assign char_data = 8'h41 + {3'b000, char_addr};

    lcd_char_driver #(
        .POWERUP_TICKS(20),
        .CLEAR_TICKS  (3)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .clk_1khz  (clk_1khz),
        .enable    (enable),
        .char_addr (char_addr),
        .char_data (char_data),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data),
        .init_done (init_done),
        .frame_done(frame_done)
    );

    initial forever #10 clk_50mhz = ~clk_50mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h (tick %0d)", tag, obs, exp, tick_num);
        end
    endtask

    task automatic push_exp(input logic [8:0] word, input int tick);
        exp_t e;
        e.word = word;
        e.tick = tick;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push_exp(9'h038, 21);
        push_exp(9'h00C, 24);
        push_exp(9'h006, 27);
        push_exp(9'h001, 30);
    endtask

    // Write k of a frame pulses at first_pulse + 3k.
    task automatic push_frame(input int first_pulse);
        logic [7:0] ch;
        push_exp(9'h080, first_pulse);
        for (int i = 0; i < 16; i++) begin
            ch = 8'h41 + 8'(i);
            push_exp({1'b1, ch}, first_pulse + 3 * (i + 1));
        end
        push_exp(9'h0C0, first_pulse + 51);
        for (int i = 16; i < 32; i++) begin
            ch = 8'h41 + 8'(i);
            push_exp({1'b1, ch}, first_pulse + 3 * (i + 2));
        end
    endtask

    task automatic observe_tick();
        exp_t e;
        if (lcd_e === 1'b1) begin
            check("e_not_two_ticks", 32'(prev_e), 32'd0);
            if (prev_e !== 1'b1) begin
                vectors++;
                assert (exp_q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL unexpected_e_pulse: observed word 0x%0h at tick %0d, expected no pulse",
                           {lcd_rs, lcd_data}, tick_num);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("pulse_word", 32'({lcd_rs, lcd_data}), 32'(e.word));
                    check("pulse_tick", 32'(tick_num), 32'(e.tick));
                    check("lcd_rw", 32'(lcd_rw), 32'd0);
                end
                last_pulse_tick = tick_num;
                last_pulse_word = {lcd_rs, lcd_data};
            end
        end
        if (frame_done === 1'b1) begin
            fd_count++;
            check("frame_done_on_hold", 32'(tick_num - last_pulse_tick), 32'd1);
            check("frame_done_last_char", 32'(last_pulse_word), 32'h160);
            check("char_addr_wrap", 32'(char_addr), 32'd0);
            fd_pending = 1'b1;
        end
        prev_e = lcd_e;
    endtask

    // One rising edge of clk_1khz; extra_high > 0 keeps the strobe stuck high afterwards.
    task automatic do_tick(input int extra_high);
        logic [16:0] snap;
        @(negedge clk_50mhz);
        clk_1khz = 1'b1;
        @(posedge clk_50mhz);
        #1;
        tick_num++;
        observe_tick();
        @(posedge clk_50mhz);
        #1;
        if (fd_pending) begin
            check("frame_done_width", 32'(frame_done), 32'd0);
            fd_pending = 1'b0;
        end
        if (extra_high > 0) begin
            snap = {lcd_e, lcd_rs, lcd_data, char_addr, init_done, frame_done};
            repeat (extra_high) @(posedge clk_50mhz);
            #1;
            check("stuck_high_no_advance",
                  32'({lcd_e, lcd_rs, lcd_data, char_addr, init_done, frame_done}), 32'(snap));
        end
        @(negedge clk_50mhz);
        clk_1khz = 1'b0;
        repeat (4) @(negedge clk_50mhz);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({lcd_e, lcd_rs, lcd_rw, lcd_data, char_addr, init_done, frame_done}), 32'd0);
    endtask

    task automatic run_init_phase();
        for (int t = 1; t <= 35; t++) begin
            do_tick(0);
            if (t <= 19) check("e_low_power_wait", 32'(lcd_e), 32'd0);
            check("init_done_level", 32'(init_done), 32'(t >= 35));
        end
    endtask

    initial begin
        // Reset held while the strobe toggles: nothing may move.
        repeat (3) begin
            repeat (3) @(negedge clk_50mhz);
            clk_1khz = 1'b1;
            repeat (3) @(negedge clk_50mhz);
            clk_1khz = 1'b0;
        end
        #1;
        check_all_zero("reset_outputs");
        check("reset_char_addr", 32'(char_addr), 32'd0);

        @(negedge clk_50mhz);
        rst    = 1'b0;
        enable = 1'b1;
        push_init();
        push_frame(36);
        run_init_phase();

        // Frame 1: writes on ticks 35..136, frame_done on tick 136.
        for (int t = 36; t <= 136; t++) do_tick(0);
        check("frame1_done_count", 32'(fd_count), 32'd1);
        check("frame1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("frame1_char_addr", 32'(char_addr), 32'd0);

        // Frame 2 starts straight away; enable drops mid-frame but the frame completes.
        push_frame(138);
        for (int t = 137; t <= 170; t++) do_tick(0);
        enable = 1'b0;
        for (int t = 171; t <= 238; t++) do_tick(0);
        check("frame2_done_count", 32'(fd_count), 32'd2);
        check("frame2_queue_empty", 32'(exp_q.size()), 32'd0);
        for (int t = 239; t <= 243; t++) begin
            do_tick(0);
            check("idle_e_low", 32'(lcd_e), 32'd0);
        end
        check("idle_bus_holds", 32'({lcd_rs, lcd_data}), 32'h160);

        // Raising enable starts the 0x80 SETUP on the very next tick.
        enable = 1'b1;
        push_frame(245);
        do_tick(0);
        check("restart_setup_bus", 32'({lcd_e, lcd_rs, lcd_data}), 32'h080);
        for (int t = 245; t <= 259; t++) do_tick(0);

        // Strobe stuck high for about ten tick periods on a PULSE tick.
        do_tick(80);
        check("stuck_tick_count", 32'(tick_num), 32'd260);
        for (int i = 0; i < 6 && lcd_e !== 1'b1; i++) do_tick(0);
        check("reached_pulse_tick", 32'(lcd_e), 32'd1);

        // Asynchronous reset mid-cycle during a PULSE tick.
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset_outputs");
        exp_q.delete();
        prev_e     = 1'b0;
        fd_pending = 1'b0;
        @(negedge clk_50mhz);
        rst      = 1'b0;
        tick_num = 0;
        push_init();
        run_init_phase();
        check("restart_queue_empty", 32'(exp_q.size()), 32'd0);
        check("restart_setup_line1", 32'({lcd_rs, lcd_data}), 32'h080);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
